// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel divider, h/v scan counters, registered sync/active/coordinate outputs.
// Optional VGA_FRAME_CNT_EN adds a 16-bit frameCount output that advances on every frame start.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        hsync,
  output logic        vsync,
  output logic        displayActive,
  output logic        pixelTick,
  output logic        startOfFrame
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0] frameCount
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS      = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS      = 11'(V_VISIBLE);
  localparam logic [10:0] HS_FIRST   = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_LAST    = 11'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [10:0] VS_FIRST   = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_LAST    = 11'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [2:0]  DIV_LAST   = 3'(CLK_DIV - 1);

  logic [2:0]  div_cnt_q, div_cnt_d;
  logic        tick;
  logic [10:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  logic        h_wrap;

  logic [10:0] pixel_x_q, pixel_y_q;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        active_q, active_d;
  logic        tick_q;
  logic        sof_q, sof_d;

  // Counter next-state: advance only on the divided pixel tick.
  always_comb begin
    tick      = (div_cnt_q == DIV_LAST);
    div_cnt_d = tick ? 3'd0 : div_cnt_q + 3'd1;
    h_wrap    = (h_cnt_q == H_LAST);
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    if (tick) begin
      h_cnt_d = h_wrap ? 11'd0 : h_cnt_q + 11'd1;
      if (h_wrap) begin
        v_cnt_d = (v_cnt_q == V_LAST) ? 11'd0 : v_cnt_q + 11'd1;
      end
    end
  end

  // Outputs are decoded from the counter values they will be presented with.
  always_comb begin
    hsync_d  = !((h_cnt_d >= HS_FIRST) && (h_cnt_d <= HS_LAST));
    vsync_d  = !((v_cnt_d >= VS_FIRST) && (v_cnt_d <= VS_LAST));
    active_d = (h_cnt_d < H_VIS) && (v_cnt_d < V_VIS);
    sof_d    = tick && (h_cnt_d == 11'd0) && (v_cnt_d == 11'd0);
  end

  // Counters park at the last position so the first tick after reset lands on (0,0).
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= 3'd0;
      h_cnt_q   <= H_LAST;
      v_cnt_q   <= V_LAST;
      pixel_x_q <= 11'd0;
      pixel_y_q <= 11'd0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      active_q  <= 1'b0;
      tick_q    <= 1'b0;
      sof_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      tick_q    <= tick;
      sof_q     <= sof_d;
      if (tick) begin
        pixel_x_q <= h_cnt_d;
        pixel_y_q <= v_cnt_d;
        hsync_q   <= hsync_d;
        vsync_q   <= vsync_d;
        active_q  <= active_d;
      end
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q <= 16'd0;
    end else if (sof_d) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frameCount = frame_cnt_q;
`endif

  assign pixelX        = pixel_x_q;
  assign pixelY        = pixel_y_q;
  assign hsync         = hsync_q;
  assign vsync         = vsync_q;
  assign displayActive = active_q;
  assign pixelTick     = tick_q;
  assign startOfFrame  = sof_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance, CLK_DIV=2 instance, and a tiny-raster instance for frame-level checks.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;

  logic [10:0] x_a, y_a, x_b, y_b, x_c, y_c;
  logic hs_a, vs_a, de_a, pt_a, sof_a;
  logic hs_b, vs_b, de_b, pt_b, sof_b;
  logic hs_c, vs_c, de_c, pt_c, sof_c;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] fc_a, fc_b, fc_c;
`endif

  vga_timing_gen u_a (
    .clk(clk), .reset(rst_a), .pixelX(x_a), .pixelY(y_a), .hsync(hs_a), .vsync(vs_a),
    .displayActive(de_a), .pixelTick(pt_a), .startOfFrame(sof_a)
`ifdef VGA_FRAME_CNT_EN
    , .frameCount(fc_a)
`endif
  );

  vga_timing_gen #(.CLK_DIV(2)) u_b (
    .clk(clk), .reset(rst_b), .pixelX(x_b), .pixelY(y_b), .hsync(hs_b), .vsync(vs_b),
    .displayActive(de_b), .pixelTick(pt_b), .startOfFrame(sof_b)
`ifdef VGA_FRAME_CNT_EN
    , .frameCount(fc_b)
`endif
  );

  // Tiny raster: 15 pixels x 8 lines, hsync low on x 10..12, vsync low on y 5..6.
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .CLK_DIV(1)
  ) u_c (
    .clk(clk), .reset(rst_c), .pixelX(x_c), .pixelY(y_c), .hsync(hs_c), .vsync(vs_c),
    .displayActive(de_c), .pixelTick(pt_c), .startOfFrame(sof_c)
`ifdef VGA_FRAME_CNT_EN
    , .frameCount(fc_c)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic rst;
    int   x;
    int   y;
    logic hs;
    logic vs;
    logic de;
    logic pt;
    logic sof;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int cx, cy, k, guard, vs_low, sof_first, sof_second;
    logic [15:0] exp_fc;

    // ---------------- table: reset, release, mid-run reset on default instance
    vecs[0] = '{1'b1, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 1, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 2, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[8] = '{1'b0, 1, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    for (int i = 0; i < 9; i++) begin
      @(negedge clk) rst_a = vecs[i].rst;
      @(posedge clk); #1;
      chk($sformatf("A.v%0d.x", i),   32'(x_a),   32'(vecs[i].x));
      chk($sformatf("A.v%0d.y", i),   32'(y_a),   32'(vecs[i].y));
      chk($sformatf("A.v%0d.hs", i),  32'(hs_a),  32'(vecs[i].hs));
      chk($sformatf("A.v%0d.vs", i),  32'(vs_a),  32'(vecs[i].vs));
      chk($sformatf("A.v%0d.de", i),  32'(de_a),  32'(vecs[i].de));
      chk($sformatf("A.v%0d.pt", i),  32'(pt_a),  32'(vecs[i].pt));
      chk($sformatf("A.v%0d.sof", i), 32'(sof_a), 32'(vecs[i].sof));
    end

    // ---------------- line scan on default instance: x 2..799, then 0,1 on line 1
    cx = 2; cy = 0;
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      chk("A.line.x", 32'(x_a), 32'(cx));
      chk("A.line.y", 32'(y_a), 32'(cy));
      chk("A.line.hs", 32'(hs_a), 32'(!(cx >= 656 && cx <= 751)));
      chk("A.line.de", 32'(de_a), 32'(cx < 640));
      chk("A.line.vs", 32'(vs_a), 32'(1));
      chk("A.line.pt", 32'(pt_a), 32'(1));
      chk("A.line.sof", 32'(sof_a), 32'(0));
`ifdef VGA_FRAME_CNT_EN
      chk("A.line.fc", 32'(fc_a), 32'(1));
`endif
      cx++;
      if (cx == 800) begin cx = 0; cy++; end
    end

    // ---------------- divided pixel clock
    @(negedge clk) rst_b = 1'b1;
    @(negedge clk) rst_b = 1'b0;
    for (k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      chk($sformatf("B.k%0d.x", k), 32'(x_b), 32'((k < 2) ? 0 : (k - 2) / 2));
      chk($sformatf("B.k%0d.y", k), 32'(y_b), 32'(0));
      chk($sformatf("B.k%0d.de", k), 32'(de_b), 32'(k >= 2));
      chk($sformatf("B.k%0d.pt", k), 32'(pt_b), 32'(k >= 2 && (k % 2) == 0));
      chk($sformatf("B.k%0d.sof", k), 32'(sof_b), 32'(k == 2));
      chk($sformatf("B.k%0d.hs", k), 32'(hs_b), 32'(1));
    end
`ifdef VGA_FRAME_CNT_EN
    chk("B.fc", 32'(fc_b), 32'(1));
`endif

    // ---------------- tiny raster: two full frames with a model
    @(negedge clk) rst_c = 1'b1;
    @(negedge clk) rst_c = 1'b0;
    cx = 0; cy = 0; vs_low = 0; sof_first = -1; sof_second = -1; exp_fc = 16'd0;
    for (k = 1; k <= 245; k++) begin
      @(posedge clk); #1;
      if (cx == 0 && cy == 0) exp_fc = exp_fc + 16'd1;
      chk("C.x", 32'(x_c), 32'(cx));
      chk("C.y", 32'(y_c), 32'(cy));
      chk("C.hs", 32'(hs_c), 32'(!(cx >= 10 && cx <= 12)));
      chk("C.vs", 32'(vs_c), 32'(!(cy >= 5 && cy <= 6)));
      chk("C.de", 32'(de_c), 32'(cx < 8 && cy < 4));
      chk("C.pt", 32'(pt_c), 32'(1));
      chk("C.sof", 32'(sof_c), 32'(cx == 0 && cy == 0));
`ifdef VGA_FRAME_CNT_EN
      chk("C.fc", 32'(fc_c), 32'(exp_fc));
`endif
      if (k <= 120 && !vs_c) vs_low++;
      if (sof_c) begin
        if (sof_first < 0) sof_first = k;
        else if (sof_second < 0) sof_second = k;
      end
      cx++;
      if (cx == 15) begin cx = 0; cy = (cy == 7) ? 0 : cy + 1; end
    end
    chk("C.vsync_low_cycles", 32'(vs_low), 32'(30));
    chk("C.frame_period", 32'(sof_second - sof_first), 32'(120));
`ifdef VGA_FRAME_CNT_EN
    chk("C.fc_after_3_frames", 32'(fc_c), 32'(3));
`endif

    // ---------------- mid-frame reset while both syncs are low
    guard = 0;
    while (!(cx == 11 && cy == 5) && guard < 200) begin
      @(posedge clk); #1;
      chk("C.seek.x", 32'(x_c), 32'(cx));
      guard++;
      cx++;
      if (cx == 15) begin cx = 0; cy = (cy == 7) ? 0 : cy + 1; end
    end
    chk("C.seek_bound", 32'(guard < 200), 32'(1));
    @(posedge clk); #1;
    chk("C.pre.x", 32'(x_c), 32'(11));
    chk("C.pre.y", 32'(y_c), 32'(5));
    chk("C.pre.hs", 32'(hs_c), 32'(0));
    chk("C.pre.vs", 32'(vs_c), 32'(0));
    @(negedge clk) rst_c = 1'b1;
    @(posedge clk); #1;
    chk("C.rst.x", 32'(x_c), 32'(0));
    chk("C.rst.y", 32'(y_c), 32'(0));
    chk("C.rst.hs", 32'(hs_c), 32'(1));
    chk("C.rst.vs", 32'(vs_c), 32'(1));
    chk("C.rst.de", 32'(de_c), 32'(0));
    chk("C.rst.pt", 32'(pt_c), 32'(0));
    chk("C.rst.sof", 32'(sof_c), 32'(0));
`ifdef VGA_FRAME_CNT_EN
    chk("C.rst.fc", 32'(fc_c), 32'(0));
`endif
    @(negedge clk) rst_c = 1'b0;
    @(posedge clk); #1;
    chk("C.restart.x", 32'(x_c), 32'(0));
    chk("C.restart.y", 32'(y_c), 32'(0));
    chk("C.restart.de", 32'(de_c), 32'(1));
    chk("C.restart.sof", 32'(sof_c), 32'(1));
    chk("C.restart.hs", 32'(hs_c), 32'(1));
    chk("C.restart.vs", 32'(vs_c), 32'(1));
`ifdef VGA_FRAME_CNT_EN
    chk("C.restart.fc", 32'(fc_c), 32'(1));
`endif
    @(posedge clk); #1;
    chk("C.next.x", 32'(x_c), 32'(1));
    chk("C.next.sof", 32'(sof_c), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Upstream pixel-timing stage of the VGA pipe. Generates the raster scan coordinates pixelX/pixelY that feed the background and object drawing stages, plus hsync/vsync for the monitor and a display-active qualifier. Default timing is 640x480@60 (800x525 total) from a pixel enable derived from clk.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
CLK_DIV, 1, clk cycles per pixel (1..8); 1 = pixel every clk

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
pixelX  out  11  current horizontal count, 0..H_TOTAL-1
pixelY  out  11  current vertical count, 0..V_TOTAL-1
hsync  out  1  horizontal sync, active-low
vsync  out  1  vertical sync, active-low
displayActive  out  1  high when pixelX<H_VISIBLE and pixelY<V_VISIBLE
pixelTick  out  1  one-clk pulse: new pixel presented on outputs
startOfFrame  out  1  one-clk pulse: outputs now show (0,0)

Behaviour:
- Derived: H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL likewise (525).
- Divider divCnt 0..CLK_DIV-1; internal tick = (divCnt==CLK_DIV-1); divCnt wraps to 0 on tick. CLK_DIV=1: tick every cycle.
- Internal hCnt/vCnt advance only on tick: hCnt+1, wrap H_TOTAL-1 -> 0; vCnt+1 only when hCnt wraps; vCnt wraps V_TOTAL-1 -> 0.
- All outputs registered, computed from the next counter values at the tick edge; latency: outputs change exactly one clk edge after the tick cycle, hold between ticks.
- hsync=0 iff next hCnt in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] (656..751); else 1.
- vsync=0 iff next vCnt in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] (490..491); else 1.
- pixelTick: 1 for the single clk following each tick edge, else 0.
- startOfFrame: 1 for the single clk in which pixelX=0 and pixelY=0 are first presented; 0 otherwise (stays 0 on later divided cycles that still show (0,0)).
- Reset (sync, dominates everything): divCnt=0, hCnt=H_TOTAL-1, vCnt=V_TOTAL-1; pixelX=0, pixelY=0, hsync=1, vsync=1, displayActive=0, pixelTick=0, startOfFrame=0. First tick after reset release wraps both counters -> outputs (0,0), displayActive=1, startOfFrame=1.
- Reset mid-frame: same as above on the next clk edge; no partial sync pulse continues.
- Counters never exceed total-1; no out-of-range coordinate ever output.

Optional Feature:
VGA_FRAME_CNT_EN: when defined, adds output port frameCount [15:0]; reset 0; increments by 1 in the same edge that asserts startOfFrame; wraps 65535 -> 0. First frame after reset shows frameCount=1. When undefined, port and logic absent; all other behaviour identical.

Test Plan:
- Reset held 3 clks, released, CLK_DIV=1 -> first edge after release: pixelX=0, pixelY=0, displayActive=1, startOfFrame=1, pixelTick=1; next edge pixelX=1, startOfFrame=0.
- CLK_DIV=2 -> pixelTick every 2nd clk; pixelX holds 2 clks per value; startOfFrame high one clk only.
- Line scan -> hsync falls when pixelX becomes 656, rises when pixelX becomes 752; displayActive falls at pixelX=640; pixelX 799 -> 0 with pixelY +1.
- Frame scan -> vsync low exactly for pixelY 490..491 (1600 pixel times); pixelY 524 & pixelX 799 -> (0,0) with startOfFrame=1; period 420000 ticks.
- Reset asserted at pixelX=700, pixelY=490 (hsync=0, vsync=0) -> next edge: hsync=1, vsync=1, all outputs at reset values; restart at (0,0).
- VGA_FRAME_CNT_EN defined -> frameCount=1 after first frame start, 3 after third; forced near wrap: 65535 -> 0 at next startOfFrame.
